router_sync: RTL

Address-latch and output-port controller for the 1x3 router. It sits between the router FSM, the input register and the three output FIFOs:
- captures the destination port while the FSM is in address decode;
- steers the FSM's write strobe to the selected FIFO and returns that FIFO's full flag;
- presents per-port valid-out;
- runs a per-port idle-read timeout that issues a soft reset to any FIFO whose data is not collected.

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_sync_timer.sv | 75 +++++++
 rtl/router_sync.sv | 117 +++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router: port count, address encoding
// and default timeout.
package router_pkg;

    localparam int NUM_PORTS       = 3;
    localparam int ADDR_W          = 2;
    localparam int DEFAULT_TIMEOUT = 30;
    localparam int DROP_W          = 8;

    // Header address encoding; the fourth code selects no output port.
    typedef enum logic [ADDR_W-1:0] {
        PORT0     = 2'b00,
        PORT1     = 2'b01,
        PORT2     = 2'b10,
        PORT_NONE = 2'b11
    } port_addr_t;

    localparam port_addr_t ADDR_INVALID = PORT_NONE;

endpackage

// File: rtl/router_sync_timer.sv
// One output port's idle-read timeout: counts valid-but-unread cycles and pulses
// soft_reset after TIMEOUT of them. Optional drop counter: ROUTER_SYNC_DROP_CNT_EN.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              vld_out,
    input  logic              read_enb,
    output logic              soft_reset
`ifdef ROUTER_SYNC_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             idle;
    logic             expire;

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        cnt_d   = '0;
        idle    = vld_out & ~read_enb;
        expire  = idle && (cnt_q == CNT_LAST);
        pulse_d = expire;
        if (idle && !expire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value, independent of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign soft_reset = pulse_q;

`ifdef ROUTER_SYNC_DROP_CNT_EN
    logic [DROP_W-1:0] drop_q, drop_d;

    // Counts on the same edge that registers the pulse; saturates at all-ones.
    always_comb begin
        drop_d = drop_q;
        if (pulse_d && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: rtl/router_sync.sv
// Router address latch, FIFO write/full steering and per-port idle timeouts.
// Optional per-port drop counters: ROUTER_SYNC_DROP_CNT_EN.
module router_sync
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic [1:0]        data_in,
    input  logic              write_enb_reg,
    input  logic              read_enb_0,
    input  logic              read_enb_1,
    input  logic              read_enb_2,
    input  logic              empty_0,
    input  logic              empty_1,
    input  logic              empty_2,
    input  logic              full_0,
    input  logic              full_1,
    input  logic              full_2,
    output logic [2:0]        write_enb,
    output logic              fifo_full,
    output logic              vld_out_0,
    output logic              vld_out_1,
    output logic              vld_out_2,
    output logic              soft_reset_0,
    output logic              soft_reset_1,
    output logic              soft_reset_2
`ifdef ROUTER_SYNC_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt_0,
    output logic [DROP_W-1:0] drop_cnt_1,
    output logic [DROP_W-1:0] drop_cnt_2
`endif
);

    port_addr_t addr_q, addr_d;

    logic [NUM_PORTS-1:0] vld_vec;
    logic [NUM_PORTS-1:0] rd_vec;
    logic [NUM_PORTS-1:0] soft_vec;

    assign addr_d = detect_add ? port_addr_t'(data_in) : addr_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q <= ADDR_INVALID;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Unregistered steering: the FIFO sees the write in the strobe's own cycle.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        case (addr_q)
            PORT0: begin
                write_enb[0] = write_enb_reg;
                fifo_full    = full_0;
            end
            PORT1: begin
                write_enb[1] = write_enb_reg;
                fifo_full    = full_1;
            end
            PORT2: begin
                write_enb[2] = write_enb_reg;
                fifo_full    = full_2;
            end
            default: begin
                write_enb = '0;
                fifo_full = 1'b0;
            end
        endcase
    end

    assign vld_vec = ~{empty_2, empty_1, empty_0};
    assign rd_vec  = {read_enb_2, read_enb_1, read_enb_0};

    assign vld_out_0 = vld_vec[0];
    assign vld_out_1 = vld_vec[1];
    assign vld_out_2 = vld_vec[2];

`ifdef ROUTER_SYNC_DROP_CNT_EN
    logic [DROP_W-1:0] drop_vec [NUM_PORTS];
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_timer (
            .clock      (clock),
            .resetn     (resetn),
            .vld_out    (vld_vec[p]),
            .read_enb   (rd_vec[p]),
            .soft_reset (soft_vec[p])
`ifdef ROUTER_SYNC_DROP_CNT_EN
            ,
            .drop_cnt   (drop_vec[p])
`endif
        );
    end

    assign soft_reset_0 = soft_vec[0];
    assign soft_reset_1 = soft_vec[1];
    assign soft_reset_2 = soft_vec[2];

`ifdef ROUTER_SYNC_DROP_CNT_EN
    assign drop_cnt_0 = drop_vec[0];
    assign drop_cnt_1 = drop_vec[1];
    assign drop_cnt_2 = drop_vec[2];
`endif

endmodule
